reorder_buffer: RTL
===================

// Module: reorder_buffer
// PURPOSE
//  Circular in-order retirement buffer for the Tomasulo core. Decoder allocates one entry
//  per issued instruction. Execution units return results on the CDB. The head entry
//  retires in program order through the ROB_we/namew/dataw/entryw write port of the
//  register file, which clears a register's lock when entryw matches.
// PARAMETERS
//  ENTRY_WIDTH  3   entry index width; DEPTH = 2**ENTRY_WIDTH (8)
//  DATA_WIDTH   32  result data width
//  REG_WIDTH    5   architectural register name width
// PORTS
//  clk          in   1            rising-edge clock
//  rst          in   1            asynchronous reset, active-low
//  alloc_req    in   1            decoder requests an entry this cycle
//  alloc_name   in   REG_WIDTH    destination register (0 = no register result)
//  alloc_ready  out  1            an entry is free; alloc_req is accepted only when 1
//  alloc_entry  out  ENTRY_WIDTH  index granted (= tail); valid in the same cycle
//  cdb_valid    in   1            result broadcast valid
//  cdb_entry    in   ENTRY_WIDTH  ROB entry the result belongs to
//  cdb_data     in   DATA_WIDTH   result value
//  q1_entry     in   ENTRY_WIDTH  operand query, port 1 (for a locked source register)
//  q1_ready     out  1            queried result is available
//  q1_data      out  DATA_WIDTH   queried result (0 when not ready)
//  q2_entry/q2_ready/q2_data      same as the q1_* ports, port 2
//  flush        in   1            synchronous squash of all entries
//  ROB_we       out  1            retire write enable to the register file
//  namew        out  REG_WIDTH    retiring destination register
//  dataw        out  DATA_WIDTH   retiring value
//  entryw       out  ENTRY_WIDTH  retiring entry index
// BEHAVIOUR
//  - State: per-entry valid, done, name, data; head and tail pointers; count (ENTRY_WIDTH+1 bits).
//  - Reset (rst=0, asynchronous): all valid/done = 0, head = tail = count = 0.
//    Outputs during reset: ROB_we=0, alloc_ready=1, alloc_entry=0, q*_ready=0.
//  - alloc_ready = (count != DEPTH). It does not count an entry freed by a same-cycle retire.
//  - Allocate (alloc_req && alloc_ready) at the edge:
//    entry[tail] <= {valid=1, done=0, name=alloc_name}; tail <= tail+1, wrapping mod DEPTH.
//  - Writeback (cdb_valid && valid[cdb_entry]) at the edge: done <= 1, data <= cdb_data.
//    A writeback to an invalid entry is ignored.
//  - Retire is combinational from head: ROB_we = valid[head] && done[head] && !flush;
//    namew/dataw/entryw = name/data/head. All zero when ROB_we=0.
//    At the edge when ROB_we=1: valid[head] <= 0; head <= head+1 (wraps).
//    Entries with name 0 still retire with ROB_we=1 and namew=0; the register file ignores that write.
//  - Latency: CDB writeback in cycle t gives the earliest ROB_we in cycle t+1.
//    Retire rate is at most one entry per cycle.
//  - count <= count + alloc - retire. Simultaneous alloc and retire leaves count unchanged.
//  - Allocating into an entry that retires in the same cycle cannot happen, because of the full rule.
//  - Query (combinational): if cdb_valid && cdb_entry==qN_entry && valid[qN_entry],
//    then ready=1 and data=cdb_data (bypass).
//    Else ready = valid && done, data = stored data.
//  - flush=1 at the edge: all valid/done cleared, head = tail = count = 0.
//    flush has priority over alloc, writeback and retire in that cycle.
//    The register file lock state is rebuilt by its owner and is not handled here.
// STRUCTURE
//  - ENTRY_WIDTH/DATA_WIDTH/REG_WIDTH defaults come from shared defines.v
//    (ROB_Entry_Width, Data_Width, Reg_Width). The ROB entry bus layout also lives there.
//  - One sub-module, rob_storage: per-entry arrays with one write port for alloc,
//    one for writeback, and three async read ports (head, q1, q2).
//  - Pointer and count logic stay in the top module.
// TESTING
//  1 Reset pulse mid-run with 3 valid entries -> immediately ROB_we=0, alloc_ready=1, alloc_entry=0.
//    After release, first alloc gets entry 0.
//  2 Alloc names 1,2,3 (entries 0,1,2); CDB writes e2=0x33, then e0=0x11 ->
//    next cycle ROB_we=1 namew=1 dataw=0x11 entryw=0; then stall with ROB_we=0.
//    CDB e1=0x22 -> e1 and e2 retire in consecutive cycles.
//  3 Eight allocs, no writeback -> alloc_ready=0; ninth alloc_req ignored, tail stays 0.
//    Write e0 -> retire -> alloc_ready=1 the cycle after; next alloc_entry=0 (wrap).
//  4 q1_entry=3 (valid, not done) with cdb_valid, cdb_entry=3, cdb_data=0xABCD ->
//    same cycle q1_ready=1, q1_data=0xABCD. Next cycle, without CDB, same values from storage.
//  5 Four pending entries, flush=1 with alloc_req=1 and cdb_valid=1 ->
//    next cycle count=0, alloc_entry=0, ROB_we=0. A later CDB write to old entry 2 is ignored.
//  6 Alloc and retire in the same cycle at count=8 -> alloc refused, count=7.
//    At count=5 -> count stays 5, both head and tail advance.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared ROB widths and per-entry status layout for the Tomasulo core.
// The parameter defaults of the ROB modules come from here.
package reorder_buffer_pkg;

  localparam int ROB_ENTRY_WIDTH = 3;
  localparam int ROB_DATA_WIDTH  = 32;
  localparam int ROB_REG_WIDTH   = 5;

  typedef struct packed {
    logic valid;
    logic done;
  } rob_status_t;

endpackage

// File: rtl/reorder_buffer_storage.sv
// Per-entry ROB arrays: alloc write port, CDB writeback port, retire-clear port,
// and three asynchronous read ports (head, q1, q2).
module rob_storage
  import reorder_buffer_pkg::*;
#(
  parameter int ENTRY_WIDTH = ROB_ENTRY_WIDTH,
  parameter int DATA_WIDTH  = ROB_DATA_WIDTH,
  parameter int REG_WIDTH   = ROB_REG_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   alloc_we,
  input  logic [ENTRY_WIDTH-1:0] alloc_idx,
  input  logic [REG_WIDTH-1:0]   alloc_name,
  input  logic                   wb_we,
  input  logic [ENTRY_WIDTH-1:0] wb_idx,
  input  logic [DATA_WIDTH-1:0]  wb_data,
  input  logic                   clr_we,
  input  logic [ENTRY_WIDTH-1:0] clr_idx,
  input  logic [ENTRY_WIDTH-1:0] head_idx,
  output logic                   head_valid,
  output logic                   head_done,
  output logic [REG_WIDTH-1:0]   head_name,
  output logic [DATA_WIDTH-1:0]  head_data,
  input  logic [ENTRY_WIDTH-1:0] q1_idx,
  output logic                   q1_valid,
  output logic                   q1_done,
  output logic [DATA_WIDTH-1:0]  q1_data,
  input  logic [ENTRY_WIDTH-1:0] q2_idx,
  output logic                   q2_valid,
  output logic                   q2_done,
  output logic [DATA_WIDTH-1:0]  q2_data
);

  localparam int DEPTH = 2 ** ENTRY_WIDTH;

  rob_status_t           status [DEPTH];
  logic [REG_WIDTH-1:0]  name   [DEPTH];
  logic [DATA_WIDTH-1:0] data   [DEPTH];

  // Writebacks to entries that are not in flight are dropped here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        status[i] <= '0;
        name[i]   <= '0;
        data[i]   <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        status[i] <= '0;
      end
    end else begin
      if (clr_we) begin
        status[clr_idx].valid <= 1'b0;
      end
      if (wb_we && status[wb_idx].valid) begin
        status[wb_idx].done <= 1'b1;
        data[wb_idx]        <= wb_data;
      end
      if (alloc_we) begin
        status[alloc_idx] <= '{valid: 1'b1, done: 1'b0};
        name[alloc_idx]   <= alloc_name;
      end
    end
  end

  assign head_valid = status[head_idx].valid;
  assign head_done  = status[head_idx].done;
  assign head_name  = name[head_idx];
  assign head_data  = data[head_idx];
  assign q1_valid   = status[q1_idx].valid;
  assign q1_done    = status[q1_idx].done;
  assign q1_data    = data[q1_idx];
  assign q2_valid   = status[q2_idx].valid;
  assign q2_done    = status[q2_idx].done;
  assign q2_data    = data[q2_idx];

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocation at tail, CDB writeback,
// operand queries with CDB bypass, and one retire per cycle from head.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ENTRY_WIDTH = ROB_ENTRY_WIDTH,
  parameter int DATA_WIDTH  = ROB_DATA_WIDTH,
  parameter int REG_WIDTH   = ROB_REG_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_req,
  input  logic [REG_WIDTH-1:0]   alloc_name,
  output logic                   alloc_ready,
  output logic [ENTRY_WIDTH-1:0] alloc_entry,
  input  logic                   cdb_valid,
  input  logic [ENTRY_WIDTH-1:0] cdb_entry,
  input  logic [DATA_WIDTH-1:0]  cdb_data,
  input  logic [ENTRY_WIDTH-1:0] q1_entry,
  output logic                   q1_ready,
  output logic [DATA_WIDTH-1:0]  q1_data,
  input  logic [ENTRY_WIDTH-1:0] q2_entry,
  output logic                   q2_ready,
  output logic [DATA_WIDTH-1:0]  q2_data,
  input  logic                   flush,
  output logic                   ROB_we,
  output logic [REG_WIDTH-1:0]   namew,
  output logic [DATA_WIDTH-1:0]  dataw,
  output logic [ENTRY_WIDTH-1:0] entryw
);

  localparam int DEPTH = 2 ** ENTRY_WIDTH;

  logic [ENTRY_WIDTH-1:0] head, tail;
  logic [ENTRY_WIDTH:0]   count;
  logic                   alloc_fire, retire;
  logic                   head_valid, head_done;
  logic [REG_WIDTH-1:0]   head_name;
  logic [DATA_WIDTH-1:0]  head_data;
  logic                   s1_valid, s1_done, s2_valid, s2_done;
  logic [DATA_WIDTH-1:0]  s1_data, s2_data;
  logic                   byp1, byp2;

  rob_storage #(
    .ENTRY_WIDTH(ENTRY_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .REG_WIDTH  (REG_WIDTH)
  ) u_storage (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .alloc_we  (alloc_fire),
    .alloc_idx (tail),
    .alloc_name(alloc_name),
    .wb_we     (cdb_valid),
    .wb_idx    (cdb_entry),
    .wb_data   (cdb_data),
    .clr_we    (retire),
    .clr_idx   (head),
    .head_idx  (head),
    .head_valid(head_valid),
    .head_done (head_done),
    .head_name (head_name),
    .head_data (head_data),
    .q1_idx    (q1_entry),
    .q1_valid  (s1_valid),
    .q1_done   (s1_done),
    .q1_data   (s1_data),
    .q2_idx    (q2_entry),
    .q2_valid  (s2_valid),
    .q2_done   (s2_done),
    .q2_data   (s2_data)
  );

  // Fullness ignores a same-cycle retire, so tail never lands on a retiring head
  assign alloc_ready = (count != (ENTRY_WIDTH + 1)'(DEPTH));
  assign alloc_entry = tail;
  assign alloc_fire  = alloc_req && alloc_ready && !flush;
  assign retire      = head_valid && head_done && !flush;

  assign ROB_we = retire;
  assign namew  = retire ? head_name : '0;
  assign dataw  = retire ? head_data : '0;
  assign entryw = retire ? head : '0;

  assign byp1     = cdb_valid && (cdb_entry == q1_entry) && s1_valid;
  assign byp2     = cdb_valid && (cdb_entry == q2_entry) && s2_valid;
  assign q1_ready = byp1 || (s1_valid && s1_done);
  assign q2_ready = byp2 || (s2_valid && s2_done);
  assign q1_data  = byp1 ? cdb_data : ((s1_valid && s1_done) ? s1_data : '0);
  assign q2_data  = byp2 ? cdb_data : ((s2_valid && s2_done) ? s2_data : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + ENTRY_WIDTH'(retire);
      tail  <= tail + ENTRY_WIDTH'(alloc_fire);
      count <= count + (ENTRY_WIDTH + 1)'(alloc_fire) - (ENTRY_WIDTH + 1)'(retire);
    end
  end

endmodule
